// File: rtl/lcd_init_sequencer.sv
// ST7735 power-up sequencer: pulses the panel reset, then streams 21 commands with their parameters to the SPI byte transmitter.
// Build option INIT_DELAY_EN: real reset/delay timing when defined; every wait phase collapses to one cycle when undefined.
module lcd_init_sequencer #(
    parameter int unsigned RST_CYCLES   = 12000,
    parameter int unsigned DELAY_CYCLES = 1440000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       cmd_rd_en,
    output logic [4:0] cmd_rd_addr,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       arg_rd_en,
    output logic [6:0] arg_rd_addr,
    input  logic [7:0] arg_data,
    input  logic       arg_valid,
    output logic       tx_valid,
    output logic [7:0] tx_byte,
    output logic       tx_dc,
    input  logic       tx_ready,
    output logic       lcd_rst_n,
    output logic       busy,
    output logic       done
);

`ifdef INIT_DELAY_EN
    localparam int unsigned RST_LEN = RST_CYCLES;
    localparam int unsigned DLY_LEN = DELAY_CYCLES;
`else
    localparam int unsigned RST_LEN = (RST_CYCLES < 1) ? RST_CYCLES : 1;
    localparam int unsigned DLY_LEN = (DELAY_CYCLES < 1) ? DELAY_CYCLES : 1;
`endif
    localparam logic [20:0] RST_LOAD = 21'(RST_LEN - 1);
    localparam logic [20:0] DLY_LOAD = 21'(DLY_LEN - 1);
    localparam logic [4:0]  LAST_CMD = 5'd20;

    // state     | meaning
    // IDLE/DONE | waiting for start (DONE: panel left in RAMWR)
    // RST_LO    | lcd_rst_n low;  RST_WAIT | post-reset settle
    // FETCH_*   | BRAM read strobe; WAIT_* | waiting for read valid
    // SEND_*    | byte offered to SPI;  DELAY | post SLPOUT/DISPON wait
    typedef enum logic [3:0] {
        IDLE, RST_LO, RST_WAIT, FETCH_CMD, WAIT_CMD, SEND_CMD,
        FETCH_ARG, WAIT_ARG, SEND_ARG, DELAY, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cmd_idx_q, cmd_idx_d;
    logic [6:0]  arg_idx_q, arg_idx_d;
    logic [4:0]  arg_left_q, arg_left_d;
    logic [20:0] timer_q, timer_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        done_q, done_d;
    logic        advance, step;

    function automatic logic [4:0] arg_count(input logic [4:0] idx);
        case (idx)
            5'd1, 5'd2, 5'd5:           arg_count = 5'd3;
            5'd3:                       arg_count = 5'd6;
            5'd4, 5'd6, 5'd10,
            5'd14, 5'd15:               arg_count = 5'd1;
            5'd7, 5'd8, 5'd9, 5'd13:    arg_count = 5'd2;
            5'd11, 5'd12:               arg_count = 5'd16;
            5'd18, 5'd19:               arg_count = 5'd4;
            default:                    arg_count = 5'd0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_idx_q  <= '0;
            arg_idx_q  <= '0;
            arg_left_q <= '0;
            timer_q    <= '0;
            tx_byte_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_idx_q  <= cmd_idx_d;
            arg_idx_q  <= arg_idx_d;
            arg_left_q <= arg_left_d;
            timer_q    <= timer_d;
            tx_byte_q  <= tx_byte_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_idx_d  = cmd_idx_q;
        arg_idx_d  = arg_idx_q;
        arg_left_d = arg_left_q;
        timer_d    = timer_q;
        tx_byte_d  = tx_byte_q;
        cmd_rd_en  = 1'b0;
        arg_rd_en  = 1'b0;
        advance    = 1'b0;
        step       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cmd_idx_d = '0;
                    arg_idx_d = '0;
                    timer_d   = RST_LOAD;
                    state_d   = RST_LO;
                end
            end
            RST_LO: begin
                if (timer_q == '0) begin
                    timer_d = RST_LOAD;
                    state_d = RST_WAIT;
                end else begin
                    timer_d = timer_q - 21'd1;
                end
            end
            RST_WAIT: begin
                if (timer_q == '0) state_d = FETCH_CMD;
                else               timer_d = timer_q - 21'd1;
            end
            FETCH_CMD: begin
                cmd_rd_en = 1'b1;
                state_d   = WAIT_CMD;
            end
            WAIT_CMD: begin
                if (cmd_valid) begin
                    tx_byte_d  = cmd_data;
                    arg_left_d = arg_count(cmd_idx_q);
                    state_d    = SEND_CMD;
                end
            end
            SEND_CMD: begin
                if (tx_ready) begin
                    if (arg_left_q != '0) state_d = FETCH_ARG;
                    else                  advance = 1'b1;
                end
            end
            FETCH_ARG: begin
                arg_rd_en = 1'b1;
                state_d   = WAIT_ARG;
            end
            WAIT_ARG: begin
                if (arg_valid) begin
                    tx_byte_d = arg_data;
                    state_d   = SEND_ARG;
                end
            end
            SEND_ARG: begin
                if (tx_ready) begin
                    arg_idx_d  = arg_idx_q + 7'd1;
                    arg_left_d = arg_left_q - 5'd1;
                    if (arg_left_q != 5'd1) state_d = FETCH_ARG;
                    else                    advance = 1'b1;
                end
            end
            DELAY: begin
                if (timer_q == '0) step = 1'b1;
                else               timer_d = timer_q - 21'd1;
            end
            default: state_d = IDLE;
        endcase

        // SLPOUT (0) and DISPON (17) need the panel wake-up time before the next command
        if (advance) begin
            if (cmd_idx_q == 5'd0 || cmd_idx_q == 5'd17) begin
                timer_d = DLY_LOAD;
                state_d = DELAY;
            end else begin
                step = 1'b1;
            end
        end
        if (step) begin
            if (cmd_idx_q == LAST_CMD) begin
                state_d = DONE;
            end else begin
                cmd_idx_d = cmd_idx_q + 5'd1;
                state_d   = FETCH_CMD;
            end
        end

        done_d = (state_d == DONE) && (state_q != DONE);
    end

    assign cmd_rd_addr = cmd_idx_q;
    assign arg_rd_addr = arg_idx_q;
    assign tx_valid    = (state_q == SEND_CMD) || (state_q == SEND_ARG);
    assign tx_dc       = (state_q == SEND_ARG);
    assign tx_byte     = tx_byte_q;
    assign lcd_rst_n   = (state_q != RST_LO);
    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = done_q;

endmodule

// File: doc/lcd_init_sequencer.md
# lcd_init_sequencer

Sequences the ST7735 power-up for the 0.96" SPI LCD PMOD. It pulses the panel hardware reset, then walks the command BRAM (indices 0–20) and the parameter BRAM. Every command and parameter byte goes out through the SPI byte transmitter with the correct DC level, and the required post-command delays are inserted. On completion the panel is left in RAMWR, and `done` hands control to the pixel streamer.

## Interface
Parameters:
- `RST_CYCLES`, 12000 — panel reset low time and post-reset settle time, each in clk cycles (1 ms at 12 MHz).
- `DELAY_CYCLES`, 1440000 — wait after SLPOUT and after DISPON (120 ms at 12 MHz); counter is 21 bits.

Ports:
- `clk` input 1 — system clock; all state on rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `start` input 1 — one-cycle pulse; begins sequence from IDLE or DONE, ignored otherwise.
- `cmd_rd_en` output 1 — read strobe to command BRAM.
- `cmd_rd_addr` output 5 — command index 0–20.
- `cmd_data` input 8 — command byte, valid with `cmd_valid`.
- `cmd_valid` input 1 — asserted exactly one cycle after `cmd_rd_en`.
- `arg_rd_en` output 1 — read strobe to parameter BRAM.
- `arg_rd_addr` output 7 — parameter index 0–67.
- `arg_data` input 8 — parameter byte.
- `arg_valid` input 1 — asserted one cycle after `arg_rd_en`.
- `tx_valid` output 1 — byte offered to SPI transmitter.
- `tx_byte` output 8 — byte to send.
- `tx_dc` output 1 — 0 = command, 1 = data.
- `tx_ready` input 1 — transmitter accepts when `tx_valid && tx_ready`.
- `lcd_rst_n` output 1 — panel hardware reset, active low.
- `busy` output 1 — high in every state except IDLE and DONE.
- `done` output 1 — one-cycle pulse on entry to DONE.

## Operation
- States: IDLE, RST_LO, RST_WAIT, FETCH_CMD, WAIT_CMD, SEND_CMD, FETCH_ARG, WAIT_ARG, SEND_ARG, DELAY, DONE.
- IDLE/DONE + `start`: clear `cmd_idx` and `arg_idx` to 0, then go to RST_LO.
- RST_LO: `lcd_rst_n` = 0 for `RST_CYCLES`, then go to RST_WAIT.
- RST_WAIT: `lcd_rst_n` = 1, wait `RST_CYCLES`, then go to FETCH_CMD.
- FETCH_CMD: `cmd_rd_en` = 1 for one cycle with `cmd_rd_addr` = `cmd_idx`, then go to WAIT_CMD.
- WAIT_CMD: on `cmd_valid`, latch `cmd_data` into `tx_byte`, load `arg_left` from the internal count table, then go to SEND_CMD.
- SEND_CMD: `tx_valid` = 1, `tx_dc` = 0; hold until accepted.
- After the command is accepted, priority is:
  - `arg_left` ≠ 0 → FETCH_ARG.
  - otherwise, delay command (index 0 SLPOUT or 17 DISPON) → DELAY.
  - otherwise, `cmd_idx` = 20 → DONE.
  - otherwise increment `cmd_idx` → FETCH_CMD.
- FETCH_ARG / WAIT_ARG / SEND_ARG: same as the command path, but use the arg BRAM and `tx_dc` = 1. On acceptance, increment `arg_idx` and decrement `arg_left`. If bytes remain, go to FETCH_ARG; otherwise apply the delay/last/next rule above.
- DELAY: count `DELAY_CYCLES`, then apply the last/next rule.
- Count table, fixed, by index 0–20: 0,3,3,6,1,3,1,2,2,2,1,16,16,2,1,1,0,0,4,4,0. Total is 68 args; index 21 is never read.
- A `cmd_valid`/`arg_valid` outside the matching WAIT state is ignored.

## Timing
- Reset values:
  - `lcd_rst_n` = 1, `done` = 0, and all other outputs 0.
  - state IDLE, all counters 0.
- `tx_byte` and `tx_dc` are stable while `tx_valid` is high and change only after acceptance. `tx_valid` never drops without acceptance.
- Per-byte overhead is 3 cycles (fetch, wait, offer) when `tx_ready` is held high. Back-to-back acceptances are never closer than 3 cycles.
- `rst` mid-sequence:
  - immediately returns the block to IDLE with the reset values above.
  - an in-flight offered byte is abandoned.
- `start` with `rst` high has no effect. `start` while `busy` is ignored.
- `done` pulses exactly once per sequence, in the cycle DONE is entered.

## Configuration
- `INIT_DELAY_EN` defined: RST_LO, RST_WAIT and DELAY use `RST_CYCLES` and `DELAY_CYCLES` as specified.
- `INIT_DELAY_EN` undefined: the wait phases are kept but are fixed at 1 cycle each. This is for fast simulation. Byte order, handshakes and `lcd_rst_n` pulse ordering are unchanged.

## Test plan
- **Full sequence** (`tx_ready` = 1, macro off): `start` → exactly 89 accepted bytes (21 with `tx_dc` = 0, 68 with `tx_dc` = 1). Order: 0x11, then 0xB1 plus 3 args, …, last byte 0x2C. One `done` pulse follows; `busy` falls with it.
- **Backpressure**: `tx_ready` low for 10 cycles while 0xB1 is offered → `tx_valid`, `tx_byte` = 0xB1 and `tx_dc` = 0 held steady. 0xB1 is accepted once, and arg index 0 follows.
- **Delays** (macro on, `DELAY_CYCLES` = 50, `RST_CYCLES` = 20):
  - `lcd_rst_n` is low for 20 cycles.
  - from 0x11 acceptance to the `tx_valid` rise for 0xB1 is 50 + 3 cycles.
  - the same 50 + 3 gap applies after 0x29.
- **Reset mid-operation**: assert `rst` during arg 5 of GMCTRP1 → all outputs return to reset values in the same cycle. A new `start` replays the sequence from 0x11 with `arg_rd_addr` = 0.
- **Start filtering**: pulse `start` while busy → byte count is still 89 with one `done`. `start` after DONE → a second complete 89-byte sequence.
